// File: rtl/anton_neopixel_stream_master.sv
// Byte-stream command decoder that drives the neopixel register bus (write/read bursts, ACK/NAK replies).
// Writes strobe one cycle after each accepted byte; reads cost 3 cycles per byte; outValid holds until outReady.
module anton_neopixel_stream_master #(
   parameter int         ADDR_BITS      = 14,
   parameter int         TIMEOUT_CYCLES = 65535,
   parameter logic [7:0] ACK_BYTE       = 8'h06,
   parameter logic [7:0] NAK_BYTE       = 8'h15
) (
   input  logic                 busClk,
   input  logic                 busResetN,
   input  logic [7:0]           inData,
   input  logic                 inValid,
   output logic                 inReady,
   output logic [7:0]           outData,
   output logic                 outValid,
   input  logic                 outReady,
   output logic [ADDR_BITS-1:0] busAddr,
   output logic [7:0]           busWriteData,
   output logic                 busWrite,
   output logic                 busRead,
   input  logic [7:0]           busReadData,
   output logic                 busy
);

   typedef enum logic [3:0] {
      IDLE, HDR_AH, HDR_AL, HDR_CNT, WDATA, RISSUE, RWAIT, ROUT, RESP
   } stateT;

   localparam logic [7:0]           OPC_WRITE = 8'h57;
   localparam logic [7:0]           OPC_READ  = 8'h52;
   localparam int                   TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0]        TO_LAST   = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);

   stateT                state, nextState;
   logic                 readyEn;
   logic                 isWrite;
   logic [ADDR_BITS-1:0] addr;
   logic [ADDR_BITS-1:0] busAddrR;
   logic [8:0]           cnt;
   logic [7:0]           outDataR;
   logic [7:0]           busWriteDataR;
   logic                 busWriteR;
   logic [TW-1:0]        toCnt;
   logic                 accept;
   logic                 timedState;
   logic                 toHit;
   logic                 opcOk;

   assign accept     = inValid && inReady;
   assign timedState = (state == HDR_AH) || (state == HDR_AL) || (state == HDR_CNT) || (state == WDATA);
   assign toHit      = (TIMEOUT_CYCLES != 0) && timedState && !inValid && (toCnt == TO_LAST);
   assign opcOk      = (inData == OPC_WRITE) || (inData == OPC_READ);

   always_ff @(posedge busClk or negedge busResetN) begin
      if (!busResetN) state <= IDLE;
      else            state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (accept) nextState = opcOk ? HDR_AH : RESP;
         HDR_AH:  if (accept) nextState = HDR_AL;  else if (toHit) nextState = RESP;
         HDR_AL:  if (accept) nextState = HDR_CNT; else if (toHit) nextState = RESP;
         HDR_CNT: if (accept) nextState = isWrite ? WDATA : RISSUE;
                  else if (toHit) nextState = RESP;
         WDATA:   if (accept) nextState = (cnt == 9'd1) ? RESP : WDATA;
                  else if (toHit) nextState = RESP;
         RISSUE:  nextState = RWAIT;
         RWAIT:   nextState = ROUT;
         ROUT:    if (outReady) nextState = (cnt == 9'd1) ? IDLE : RISSUE;
         RESP:    if (outReady) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      inReady  = 1'b0;
      outValid = 1'b0;
      busRead  = 1'b0;
      busy     = (state != IDLE);
      case (state)
         IDLE, HDR_AH, HDR_AL, HDR_CNT, WDATA: inReady  = readyEn;
         RISSUE:                               busRead  = 1'b1;
         ROUT, RESP:                           outValid = 1'b1;
         default: ;
      endcase
   end

   assign outData      = outDataR;
   assign busWrite     = busWriteR;
   assign busWriteData = busWriteDataR;
   // Reads present the live address; writes present the address captured with their data byte.
   assign busAddr      = (state == RISSUE) ? addr : busAddrR;

   always_ff @(posedge busClk or negedge busResetN) begin
      if (!busResetN) begin
         readyEn       <= 1'b0;
         isWrite       <= 1'b0;
         addr          <= '0;
         busAddrR      <= '0;
         cnt           <= '0;
         outDataR      <= '0;
         busWriteDataR <= '0;
         busWriteR     <= 1'b0;
         toCnt         <= '0;
      end else begin
         readyEn   <= 1'b1;
         busWriteR <= 1'b0;
         if (timedState && !inValid && !toHit) toCnt <= toCnt + TW'(1);
         else                                  toCnt <= '0;
         case (state)
            IDLE: if (accept) begin
               isWrite <= (inData == OPC_WRITE);
               if (!opcOk) outDataR <= NAK_BYTE;
            end
            HDR_AH:  if (accept) addr[ADDR_BITS-1:8] <= inData[ADDR_BITS-9:0];
            HDR_AL:  if (accept) addr[7:0] <= inData;
            HDR_CNT: if (accept) cnt <= {1'b0, inData} + 9'd1;
            WDATA: if (accept) begin
               busWriteR     <= 1'b1;
               busAddrR      <= addr;
               busWriteDataR <= inData;
               addr          <= addr + ADDR_ONE;
               cnt           <= cnt - 9'd1;
               if (cnt == 9'd1) outDataR <= ACK_BYTE;
            end
            RWAIT: outDataR <= busReadData;
            ROUT: if (outReady) begin
               addr <= addr + ADDR_ONE;
               cnt  <= cnt - 9'd1;
            end
            default: ;
         endcase
         if (toHit) outDataR <= NAK_BYTE;
      end
   end

endmodule

// File: tb/tb_anton_neopixel_stream_master.sv
// Directed bench for anton_neopixel_stream_master; the register block is modelled as readData = addr[7:0] ^ 8'h02.
module tb_anton_neopixel_stream_master;

   logic        busClk = 1'b0;
   logic        busResetN;
   logic [7:0]  inData;
   logic        inValid;
   logic        inReady;
   logic [7:0]  outData;
   logic        outValid;
   logic        outReady;
   logic [13:0] busAddr;
   logic [7:0]  busWriteData;
   logic        busWrite;
   logic        busRead;
   logic [7:0]  busReadData;
   logic        busy;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic [21:0] wrQ[$];
   int          wrCyc[$];
   logic [13:0] rdQ[$];
   logic [7:0]  txQ[$];
   logic [13:0] lastRdAddr = '0;
   logic        conflict = 1'b0;

   always #5 busClk = ~busClk;

   anton_neopixel_stream_master #(
      .ADDR_BITS(14), .TIMEOUT_CYCLES(8), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)
   ) dut (
      .busClk(busClk), .busResetN(busResetN),
      .inData(inData), .inValid(inValid), .inReady(inReady),
      .outData(outData), .outValid(outValid), .outReady(outReady),
      .busAddr(busAddr), .busWriteData(busWriteData),
      .busWrite(busWrite), .busRead(busRead),
      .busReadData(busReadData), .busy(busy)
   );

   assign busReadData = lastRdAddr[7:0] ^ 8'h02;

   always @(negedge busClk) begin
      cyc++;
      if (busWrite) begin
         wrQ.push_back({busAddr, busWriteData});
         wrCyc.push_back(cyc);
      end
      if (busRead) begin
         rdQ.push_back(busAddr);
         lastRdAddr = busAddr;
      end
      if (busWrite && busRead) conflict = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge busClk);
      #1;
   endtask

   task automatic sendQ(input string tag);
      int n;
      foreach (txQ[i]) begin
         inData  = txQ[i];
         inValid = 1'b1;
         n = 0;
         while (!inReady && n < 20) begin
            step();
            n++;
         end
         if (!inReady) check({tag, "_rdy"}, 32'(inReady), 32'd1);
         step();
      end
      inValid = 1'b0;
   endtask

   task automatic waitOut(input string tag, input logic [7:0] exp, output int n);
      n = 0;
      while (!outValid && n < 40) begin
         step();
         n++;
      end
      check({tag, "_vld"}, 32'(outValid), 32'd1);
      check({tag, "_dat"}, 32'(outData), 32'(exp));
      if (outReady) step();
   endtask

   task automatic waitIdle(input string tag);
      int n;
      n = 0;
      while (busy && n < 40) begin
         step();
         n++;
      end
      check(tag, 32'(busy), 32'd0);
   endtask

   task automatic checkQuiet(input string tag, input int cycles);
      logic seen;
      seen = 1'b0;
      repeat (cycles) begin
         step();
         if (outValid) seen = 1'b1;
      end
      check(tag, 32'(seen), 32'd0);
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, "_ctl"}, 32'({inReady, outValid, busWrite, busRead, busy}), 32'd0);
      check({tag, "_dat"}, 32'({outData, busWriteData}), 32'd0);
      check({tag, "_addr"}, 32'(busAddr), 32'd0);
   endtask

   task automatic clearQ();
      wrQ.delete();
      wrCyc.delete();
      rdQ.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      logic stable;
      busResetN = 1'b0;
      inValid   = 1'b0;
      inData    = 8'h00;
      outReady  = 1'b1;

      // Reset state and release behaviour
      #12;
      checkAllZero("rst");
      @(posedge busClk); #1;
      busResetN = 1'b1;
      check("rst_rdy_low", 32'(inReady), 32'd0);
      step();
      check("rst_rdy_high", 32'(inReady), 32'd1);

      // 1: three-byte write burst, back-to-back strobes then ACK
      clearQ();
      txQ = {8'h57, 8'h20, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC};
      sendQ("t1");
      waitOut("t1_ack", 8'h06, n);
      check("t1_wcount", 32'(wrQ.size()), 32'd3);
      check("t1_w0", 32'(wrQ[0]), 32'({14'h2000, 8'hAA}));
      check("t1_w1", 32'(wrQ[1]), 32'({14'h2001, 8'hBB}));
      check("t1_w2", 32'(wrQ[2]), 32'({14'h2002, 8'hCC}));
      check("t1_gap01", 32'(wrCyc[1] - wrCyc[0]), 32'd1);
      check("t1_gap12", 32'(wrCyc[2] - wrCyc[1]), 32'd1);
      waitIdle("t1_idle");

      // 2: single read, no trailing ACK
      clearQ();
      txQ = {8'h52, 8'h20, 8'h03, 8'h00};
      sendQ("t2");
      waitOut("t2_rd", 8'h01, n);
      checkQuiet("t2_no_ack", 5);
      check("t2_rcount", 32'(rdQ.size()), 32'd1);
      check("t2_raddr", 32'(rdQ[0]), 32'h2003);
      check("t2_busy", 32'(busy), 32'd0);

      // 3: two reads wrapping 3FFF -> 0000 with a 10-cycle stall on the first byte
      clearQ();
      outReady = 1'b0;
      txQ = {8'h52, 8'h3F, 8'hFF, 8'h01};
      sendQ("t3");
      waitOut("t3_b0", 8'hFD, n);
      stable = 1'b1;
      repeat (10) begin
         step();
         if (!(outValid === 1'b1 && outData === 8'hFD)) stable = 1'b0;
      end
      check("t3_stable", 32'(stable), 32'd1);
      check("t3_one_read", 32'(rdQ.size()), 32'd1);
      outReady = 1'b1;
      step();
      waitOut("t3_b1", 8'h02, n);
      check("t3_rcount", 32'(rdQ.size()), 32'd2);
      check("t3_raddr0", 32'(rdQ[0]), 32'h3FFF);
      check("t3_raddr1", 32'(rdQ[1]), 32'h0000);
      waitIdle("t3_idle");

      // 4: bad opcode, then a normal read
      clearQ();
      txQ = {8'h41};
      sendQ("t4");
      waitOut("t4_nak", 8'h15, n);
      check("t4_no_strobe", 32'(wrQ.size() + rdQ.size()), 32'd0);
      txQ = {8'h52, 8'h00, 8'h05, 8'h00};
      sendQ("t4r");
      waitOut("t4_rd", 8'h07, n);
      check("t4_raddr", 32'(rdQ[0]), 32'h0005);
      waitIdle("t4_idle");

      // 5: timeout mid-write after one data byte
      clearQ();
      txQ = {8'h57, 8'h00, 8'h00, 8'h03, 8'h11};
      sendQ("t5");
      waitOut("t5_nak", 8'h15, n);
      check("t5_delay", 32'(n), 32'd8);
      check("t5_wcount", 32'(wrQ.size()), 32'd1);
      check("t5_w0", 32'(wrQ[0]), 32'({14'h0000, 8'h11}));
      waitIdle("t5_idle");

      // 6a: reset during WDATA, then a fresh write
      txQ = {8'h57, 8'h01, 8'h00, 8'h05, 8'h22};
      sendQ("t6a");
      #2 busResetN = 1'b0;
      #1 checkAllZero("t6a_rst");
      step();
      busResetN = 1'b1;
      step();
      check("t6a_rdy", 32'(inReady), 32'd1);
      check("t6a_busy", 32'(busy), 32'd0);
      clearQ();
      txQ = {8'h57, 8'h01, 8'h10, 8'h00, 8'h33};
      sendQ("t6a2");
      waitOut("t6a_ack", 8'h06, n);
      check("t6a_wcount", 32'(wrQ.size()), 32'd1);
      check("t6a_w0", 32'(wrQ[0]), 32'({14'h0110, 8'h33}));
      waitIdle("t6a_idle");

      // 6b: reset during ROUT, then a fresh read
      outReady = 1'b0;
      txQ = {8'h52, 8'h00, 8'h07, 8'h00};
      sendQ("t6b");
      waitOut("t6b_rd", 8'h05, n);
      #2 busResetN = 1'b0;
      #1 checkAllZero("t6b_rst");
      step();
      busResetN = 1'b1;
      outReady  = 1'b1;
      step();
      check("t6b_rdy", 32'(inReady), 32'd1);
      clearQ();
      txQ = {8'h52, 8'h00, 8'h08, 8'h00};
      sendQ("t6b2");
      waitOut("t6b_rd2", 8'h0A, n);
      check("t6b_raddr", 32'(rdQ[0]), 32'h0008);
      waitIdle("t6b_idle");

      check("strobe_exclusive", 32'(conflict), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
